// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the unified-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Encodings match funct3[1:0] of the load/store instructions.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // The reserved encoding 2'b11 is issued to memory as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        case (size)
            SZ_BYTE: return SZ_BYTE;
            SZ_HALF: return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Two-way round-robin selector, one-hot grant (bit0 fetch, bit1 data).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_owner,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_owner == OWN_I) ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one fixed-latency memory port between fetch and data.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            r_state;
    owner_e            r_owner;
    owner_e            r_last_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_req;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        r_mem_size;
    logic              r_i_rvalid;
    logic              r_d_done;

    logic [1:0]        w_pick;
    logic [1:0]        w_gnt;

    rr_pick2 u_pick (
        .req        ({d_req, i_req}),
        .last_owner (r_last_owner),
        .gnt        (w_pick)
    );

    // Reset gates the grant so nothing is accepted while reset is held.
    assign w_gnt = (r_state == IDLE && !reset) ? w_pick : 2'b00;

    assign i_gnt     = w_gnt[0];
    assign d_gnt     = w_gnt[1];
    assign i_rvalid  = r_i_rvalid;
    assign d_done    = r_d_done;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_req   = r_mem_req;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_size  = r_mem_size;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= OWN_I;
            r_last_owner <= OWN_I;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_size   <= 2'b00;
            r_i_rvalid   <= 1'b0;
            r_d_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt[1]) begin
                        r_state      <= ISSUE;
                        r_owner      <= OWN_D;
                        r_last_owner <= OWN_D;
                        r_cnt        <= CNT_LOAD;
                        r_mem_req    <= 1'b1;
                        r_mem_rw     <= d_rw;
                        r_mem_addr   <= d_addr;
                        r_mem_wdata  <= d_wdata;
                        r_mem_size   <= norm_size(d_size);
                    end else if (w_gnt[0]) begin
                        r_state      <= ISSUE;
                        r_owner      <= OWN_I;
                        r_last_owner <= OWN_I;
                        r_cnt        <= CNT_LOAD;
                        r_mem_req    <= 1'b1;
                        r_mem_rw     <= 1'b0;
                        r_mem_addr   <= i_addr;
                        r_mem_wdata  <= '0;
                        r_mem_size   <= SZ_WORD;
                    end
                end
                ISSUE: begin
                    r_mem_req <= 1'b0;
                    // A zero load means single-cycle latency: skip WAIT entirely.
                    if (r_cnt == '0) begin
                        r_state    <= RESP;
                        r_i_rvalid <= (r_owner == OWN_I);
                        r_d_done   <= (r_owner == OWN_D);
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_ONE) begin
                        r_state    <= RESP;
                        r_i_rvalid <= (r_owner == OWN_I);
                        r_d_done   <= (r_owner == OWN_D);
                    end
                end
                RESP: begin
                    r_state    <= IDLE;
                    r_i_rvalid <= 1'b0;
                    r_d_done   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
